// File: rtl/mips_pkg.sv
// Shared definitions for the 16-bit MIPS pipeline front end.
//   DATA_W   : instruction and address width
//   RESET_PC : PC loaded on reset
//   fetch_state_e : fetch FSM states (RUN, FLUSH)
package mips_pkg;

    localparam int unsigned DATA_W = 16;
    localparam logic [DATA_W-1:0] RESET_PC = 16'h0000;

    typedef enum logic [0:0] {
        RUN,
        FLUSH
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue_if.sv
// Handshake bundle between the fetch queue, the instruction memory, the
// branch resolver and the IF/ID register.
//   master : fetch queue side (drives requests and decode outputs)
//   slave  : environment side (memory, redirect source, decode)
interface fetch_queue_if #(
    parameter int unsigned DATA_W = mips_pkg::DATA_W
);

    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [DATA_W-1:0] imem_req_addr;
    logic              imem_resp_valid;
    logic [DATA_W-1:0] imem_resp_data;
    logic              redirect;
    logic [DATA_W-1:0] redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [DATA_W-1:0] out_pc_plus1;

    modport master (
        output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc_plus1,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect, redirect_pc,
        input  out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc_plus1,
        output imem_req_ready, imem_resp_valid, imem_resp_data, redirect, redirect_pc,
        output out_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a registered head entry.
//   clk, reset : clock and synchronous active-high reset (zeroes all entries)
//   clear      : drop all entries (takes priority over push/pop)
//   push, push_data : write an entry at the tail
//   pop        : remove the head entry
//   head_valid, head_data : registered head of the queue
//   count      : number of entries held
// Entries are kept as a shift register so the head is always entry 0.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic                         head_valid,
    output logic [WIDTH-1:0]             head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q;
    logic             do_pop, do_push;
    logic [CNT_W-1:0] wr_idx;

    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    // A simultaneous pop shifts everything down, so the tail slot moves by one.
    assign wr_idx  = do_pop ? count_q - CNT_W'(1) : count_q;

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (do_pop) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                mem_d[i] = mem_q[i + 1];
            end
            count_d = count_d - CNT_W'(1);
        end
        if (do_push) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (CNT_W'(i) == wr_idx) begin
                    mem_d[i] = push_data;
                end
            end
            count_d = count_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            count_q <= '0;
            valid_q <= 1'b0;
        end else if (clear) begin
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
            valid_q <= (count_d != '0);
        end
    end

    assign head_valid = valid_q;
    assign head_data  = mem_q[0];
    assign count      = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Decoupled instruction-fetch front end. Owns the PC, issues in-order
// requests to a handshaked instruction memory, buffers returned words with
// their PC+1 and hands them to IF/ID under valid/ready. A redirect reloads
// the PC, clears the buffer and discards fetches still in flight.
//   clk, reset : clock and synchronous active-high reset
//   bus        : fetch_queue_if.master (imem req/resp, redirect, decode output)
module fetch_queue #(
    parameter int unsigned       DATA_W   = mips_pkg::DATA_W,
    parameter int unsigned       DEPTH    = 3,
    parameter logic [DATA_W-1:0] RESET_PC = mips_pkg::RESET_PC
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.master bus
);

    import mips_pkg::*;

    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned ENTRY_W = 2 * DATA_W;

    fetch_state_e      state_q;
    logic [DATA_W-1:0] pc_q;
    logic [CNT_W-1:0]  outstanding_q;
    logic [CNT_W-1:0]  discard_q;
    logic [CNT_W-1:0]  outstanding_left;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    in_flight;
    logic              req_valid, req_fire, resp_fire, push, pop, fifo_valid;
    logic [DATA_W-1:0] resp_pc;
    logic [ENTRY_W-1:0] fifo_head;

    // Buffered plus outstanding fetches never exceed DEPTH, so the queue cannot
    // overflow no matter how long decode stalls.
    assign in_flight = (CNT_W+1)'(outstanding_q) + (CNT_W+1)'(fifo_count);
    assign req_valid = !reset && (state_q == RUN) && !bus.redirect &&
                       (in_flight < (CNT_W+1)'(DEPTH));
    assign req_fire  = req_valid && bus.imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp_fire        = bus.imem_resp_valid && (outstanding_q != '0);
    assign outstanding_left = outstanding_q - CNT_W'(resp_fire);
    // Oldest outstanding address; responses come back in issue order.
    assign resp_pc          = pc_q - DATA_W'(outstanding_q);

    assign push = resp_fire && (state_q == RUN) && !bus.redirect;
    assign pop  = fifo_valid && bus.out_ready;

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .clear      (bus.redirect),
        .push       (push),
        .push_data  ({bus.imem_resp_data, resp_pc + DATA_W'(1)}),
        .pop        (pop),
        .head_valid (fifo_valid),
        .head_data  (fifo_head),
        .count      (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else if (bus.redirect) begin
            // A response landing this cycle is stale and already accounted for.
            pc_q          <= bus.redirect_pc;
            outstanding_q <= outstanding_left;
            discard_q     <= outstanding_left;
            state_q       <= (outstanding_left != '0) ? FLUSH : RUN;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (req_fire) begin
                        pc_q <= pc_q + DATA_W'(1);
                    end
                    outstanding_q <= outstanding_left + CNT_W'(req_fire);
                end
                FLUSH: begin
                    outstanding_q <= outstanding_left;
                    if (resp_fire) begin
                        discard_q <= discard_q - CNT_W'(1);
                        if (discard_q == CNT_W'(1)) begin
                            state_q <= RUN;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.out_valid      = fifo_valid;
    assign bus.out_instr      = fifo_head[ENTRY_W-1 -: DATA_W];
    assign bus.out_pc_plus1   = fifo_head[DATA_W-1:0];

    resp_without_fetch: assert property (@(posedge clk) disable iff (reset)
        !(bus.imem_resp_valid && (outstanding_q == '0)));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a table of per-cycle vectors for streaming
// and stall behaviour, plus hand-written redirect and reset sequences.
// The instruction memory model returns addr ^ 16'hA500 after a fixed latency.
module tb_fetch_queue;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_queue_if bus ();

    fetch_queue #(
        .DEPTH    (3),
        .RESET_PC (16'h0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] addr;
        int unsigned due;
    } mem_req_t;

    typedef struct {
        logic        rst;
        logic        ordy;
        logic        chk;
        logic        rv;
        logic [15:0] addr;
        logic        ov;
        logic [15:0] instr;
        logic [15:0] pc1;
    } vec_t;

    mem_req_t    mq[$];
    vec_t        vt[$];
    int unsigned cyc = 0;
    int unsigned lat = 1;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned acc_cnt = 0;
    logic        last_acc;
    logic [15:0] last_acc_addr;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive this cycle's memory response, then let combinational outputs settle.
    task automatic drive_mem();
        if (reset) begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = '0;
        end else if (mq.size() != 0 && mq[0].due <= cyc) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = mq[0].addr ^ 16'hA500;
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = '0;
        end
        #1;
    endtask

    // Record this cycle's handshakes in the memory model and advance one cycle.
    task automatic clock_edge();
        mem_req_t r;
        last_acc      = bus.imem_req_valid && bus.imem_req_ready;
        last_acc_addr = bus.imem_req_addr;
        if (reset) begin
            mq.delete();
        end else begin
            if (bus.imem_resp_valid) mq.delete(0);
            if (last_acc) begin
                r.addr = last_acc_addr;
                r.due  = cyc + lat;
                mq.push_back(r);
                acc_cnt++;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset(input int unsigned l);
        reset = 1'b1;
        lat   = l;
        drive_mem();
        clock_edge();
        drive_mem();
        clock_edge();
        reset   = 1'b0;
        acc_cnt = 0;
    endtask

    task automatic add(input logic r, input logic o, input logic c, input logic v,
                       input logic [15:0] a, input logic ov, input logic [15:0] ins,
                       input logic [15:0] p);
        vec_t x;
        x.rst = r; x.ordy = o; x.chk = c; x.rv = v;
        x.addr = a; x.ov = ov; x.instr = ins; x.pc1 = p;
        vt.push_back(x);
    endtask

    task automatic apply_row(input int i);
        reset         = vt[i].rst;
        bus.out_ready = vt[i].ordy;
        drive_mem();
        if (vt[i].chk) begin
            chk($sformatf("row%0d req_valid", i), 16'(bus.imem_req_valid), 16'(vt[i].rv));
            chk($sformatf("row%0d req_addr", i), bus.imem_req_addr, vt[i].addr);
            chk($sformatf("row%0d out_valid", i), 16'(bus.out_valid), 16'(vt[i].ov));
            chk($sformatf("row%0d out_instr", i), bus.out_instr, vt[i].instr);
            chk($sformatf("row%0d out_pc_plus1", i), bus.out_pc_plus1, vt[i].pc1);
        end
        clock_edge();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned waited;
        logic [15:0] exp_a [3];
        logic [15:0] exp_p [3];
        logic [15:0] exp_i [3];

        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.redirect        = 1'b0;
        bus.redirect_pc     = '0;
        bus.out_ready       = 1'b1;

        // Streaming after reset, one-cycle memory, decode always ready.
        add(1, 1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000);
        add(1, 1, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000);
        add(0, 1, 1, 1, 16'h0000, 0, 16'h0000, 16'h0000);
        add(0, 1, 1, 1, 16'h0001, 0, 16'h0000, 16'h0000);
        add(0, 1, 1, 1, 16'h0002, 1, 16'hA500, 16'h0001);
        add(0, 1, 1, 1, 16'h0003, 1, 16'hA501, 16'h0002);
        add(0, 1, 1, 1, 16'h0004, 1, 16'hA502, 16'h0003);
        add(0, 1, 1, 1, 16'h0005, 1, 16'hA503, 16'h0004);
        // Reset mid-stream, then decode stalled for 10 cycles.
        add(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000);
        add(1, 0, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000);
        add(0, 0, 1, 1, 16'h0000, 0, 16'h0000, 16'h0000);
        add(0, 0, 1, 1, 16'h0001, 0, 16'h0000, 16'h0000);
        add(0, 0, 1, 1, 16'h0002, 1, 16'hA500, 16'h0001);
        for (int k = 0; k < 7; k++) add(0, 0, 1, 0, 16'h0003, 1, 16'hA500, 16'h0001);
        // Release: drain in order, fetching resumes at 3.
        add(0, 1, 1, 0, 16'h0003, 1, 16'hA500, 16'h0001);
        add(0, 1, 1, 1, 16'h0003, 1, 16'hA501, 16'h0002);
        add(0, 1, 1, 1, 16'h0004, 1, 16'hA502, 16'h0003);
        add(0, 1, 1, 1, 16'h0005, 1, 16'hA503, 16'h0004);

        @(negedge clk);
        for (int i = 0; i < 8; i++) apply_row(i);
        acc_cnt = 0;
        for (int i = 8; i < 20; i++) apply_row(i);
        chk("accepts_while_stalled", 16'(acc_cnt), 16'd3);
        for (int i = 20; i < vt.size(); i++) apply_row(i);

        // Redirect with two fetches outstanding on a 3-cycle memory.
        do_reset(3);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_mem();
            clock_edge();
        end
        chk("outstanding_before_redirect", 16'(acc_cnt), 16'd2);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0040;
        drive_mem();
        chk("flush_redirect_blocks_req", 16'(bus.imem_req_valid), 16'd0);
        clock_edge();
        bus.redirect = 1'b0;
        chk("flush_out_valid_after_redirect", 16'(bus.out_valid), 16'd0);
        waited = 0;
        drive_mem();
        while (!bus.imem_req_valid && waited < 20) begin
            clock_edge();
            drive_mem();
            waited++;
        end
        chk("flush_cycles", 16'(waited), 16'd2);
        chk("flush_next_addr", bus.imem_req_addr, 16'h0040);
        clock_edge();
        waited = 0;
        while (!bus.out_valid && waited < 20) begin
            drive_mem();
            clock_edge();
            waited++;
        end
        chk("flush_delivery_wait", 16'(waited), 16'd3);
        chk("flush_first_pc_plus1", bus.out_pc_plus1, 16'h0041);
        chk("flush_first_instr", bus.out_instr, 16'hA540);

        // Redirect coinciding with a response and a pending request.
        do_reset(1);
        bus.out_ready = 1'b1;
        repeat (4) begin
            drive_mem();
            clock_edge();
        end
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0100;
        drive_mem();
        chk("coinc_req_valid", 16'(bus.imem_req_valid), 16'd0);
        clock_edge();
        bus.redirect = 1'b0;
        chk("coinc_out_valid_n1", 16'(bus.out_valid), 16'd0);
        drive_mem();
        chk("coinc_next_req_valid", 16'(bus.imem_req_valid), 16'd1);
        chk("coinc_next_addr", bus.imem_req_addr, 16'h0100);
        clock_edge();
        chk("coinc_out_valid_n2", 16'(bus.out_valid), 16'd0);
        drive_mem();
        clock_edge();
        chk("coinc_out_valid_n3", 16'(bus.out_valid), 16'd1);
        chk("coinc_pc_plus1", bus.out_pc_plus1, 16'h0101);
        chk("coinc_instr", bus.out_instr, 16'hA400);

        // Redirect near the top of the address space: PC wraps.
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'hFFFE;
        drive_mem();
        clock_edge();
        bus.redirect = 1'b0;
        exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000};
        exp_p = '{16'hFFFF, 16'h0000, 16'h0001};
        exp_i = '{16'h5AFE, 16'h5AFF, 16'hA500};
        for (int j = 0; j < 5; j++) begin
            drive_mem();
            if (j < 3) begin
                chk($sformatf("wrap_req_valid%0d", j), 16'(bus.imem_req_valid), 16'd1);
                chk($sformatf("wrap_addr%0d", j), bus.imem_req_addr, exp_a[j]);
            end
            if (j < 2) begin
                chk($sformatf("wrap_out_valid%0d", j), 16'(bus.out_valid), 16'd0);
            end else begin
                chk($sformatf("wrap_out_valid%0d", j), 16'(bus.out_valid), 16'd1);
                chk($sformatf("wrap_pc_plus1_%0d", j), bus.out_pc_plus1, exp_p[j-2]);
                chk($sformatf("wrap_instr%0d", j), bus.out_instr, exp_i[j-2]);
            end
            clock_edge();
        end

        // Fill the queue with decode stalled, then reset with nothing outstanding.
        bus.out_ready = 1'b0;
        repeat (6) begin
            drive_mem();
            clock_edge();
        end
        drive_mem();
        chk("full_out_valid", 16'(bus.out_valid), 16'd1);
        chk("full_req_valid", 16'(bus.imem_req_valid), 16'd0);
        reset = 1'b1;
        drive_mem();
        chk("rst_cycle_req_valid", 16'(bus.imem_req_valid), 16'd0);
        clock_edge();
        drive_mem();
        chk("rst_next_out_valid", 16'(bus.out_valid), 16'd0);
        chk("rst_next_req_valid", 16'(bus.imem_req_valid), 16'd0);
        chk("rst_next_out_instr", bus.out_instr, 16'h0000);
        chk("rst_next_pc_plus1", bus.out_pc_plus1, 16'h0000);
        clock_edge();
        reset = 1'b0;
        drive_mem();
        chk("post_rst_req_valid", 16'(bus.imem_req_valid), 16'd1);
        chk("post_rst_addr", bus.imem_req_addr, 16'h0000);
        clock_edge();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupled instruction-fetch front end for the 16-bit five-stage MIPS pipeline. It sits directly upstream of the IF/ID pipeline register and replaces the fixed single-cycle instruction lookup. It owns the PC and issues in-order requests to a handshaked instruction memory. Returned instructions are buffered with their PC+1 and presented to decode under valid/ready flow control. A taken branch from the memory stage redirects the PC and flushes all buffered and in-flight fetches.

## Interface
Parameters:
- DATA_W, 16, instruction and address width
- DEPTH, 3, queue entries, which is also the cap on buffered plus outstanding fetches
- RESET_PC, 16'h0000, PC loaded on reset

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- imem_req_valid  out  1  fetch request
- imem_req_ready  in  1  memory accepts the request
- imem_req_addr  out  DATA_W  word address (the PC)
- imem_resp_valid  in  1  instruction returned; responses arrive in order, at least one cycle after acceptance
- imem_resp_data  in  DATA_W  instruction word
- redirect  in  1  taken branch (pcSrc)
- redirect_pc  in  DATA_W  branch target
- out_valid  out  1  instruction available to IF/ID
- out_ready  in  1  IF/ID accepts; low while decode stalls
- out_instr  out  DATA_W  instruction
- out_pc_plus1  out  DATA_W  address of the instruction + 1

## Operation
- Addressing is word-based. PC advances by 1 per accepted request and wraps from 16'hFFFF to 16'h0000.
- Credit rule: imem_req_valid = (state==RUN) && !redirect && (outstanding + count < DEPTH). out_ready is not in this path.
- A request completes when imem_req_valid && imem_req_ready. On completion, PC <= PC+1 and outstanding increments.
- In state RUN, each response pushes {imem_resp_data, addr+1} into the queue and decrements outstanding. The addr value comes from a shadow FIFO of issued addresses, or equivalently PC − outstanding.
- Pop occurs on out_valid && out_ready. Push and pop in the same cycle leave count unchanged.
- FSM states:
  - RUN: normal operation.
  - FLUSH: discarding stale responses.
- On redirect, in any state:
  - queue cleared and PC <= redirect_pc;
  - discard <= outstanding minus any response arriving that cycle;
  - any response arriving that cycle is dropped;
  - next state is FLUSH if discard > 0, otherwise RUN.
- In FLUSH, every response decrements both discard and outstanding, and nothing is pushed. When discard reaches 0, the block returns to RUN. No requests issue while in FLUSH.
- A redirect during FLUSH reloads PC and recomputes discard by the same rule.
- Responses that arrive with outstanding == 0 are a protocol error: they are ignored and trigger a simulation assertion.

## Timing
- During reset and on the cycle it is applied, all state clears:
  - PC=RESET_PC, count=0, outstanding=0, discard=0, state=RUN;
  - out_valid=0, imem_req_valid=0;
  - out_instr=0, out_pc_plus1=0.
- First cycle after reset deasserts: imem_req_valid=1, imem_req_addr=RESET_PC.
- Outputs are registered from the queue head. Latency is request accepted at cycle N → response at N+1 (zero-wait memory) → out_valid at N+2.
- Throughput: DEPTH=3 sustains one instruction per cycle with a one-cycle memory. With out_ready=0, at most DEPTH fetches are buffered or outstanding, and no overflow occurs.
- Redirect at cycle N: out_valid=0 at N+1. When no fetches are outstanding, the request for redirect_pc issues at N+1.
- Reset in mid-operation discards everything. The memory is reset by the same signal, so no stale responses follow.

## Structure
- The shared package mips_pkg holds DATA_W, RESET_PC and the fetch-state enum {RUN, FLUSH}.
- The sub-module fetch_fifo is a parameterised DEPTH×(2·DATA_W) synchronous FIFO with push, pop, clear, count and a registered head. It also serves later queues.
- fetch_queue contains the PC, the outstanding and discard counters, and the FSM.

## Test plan
- Reset, then imem_req_ready=1, one-cycle memory returning addr^16'hA500, and out_ready=1:
  - addresses 0,1,2,… issue one per cycle;
  - out_valid rises 2 cycles after reset deasserts;
  - out_instr=16'hA500 with out_pc_plus1=1, then 16'hA501 with 2, every cycle.
- Hold out_ready=0 for 10 cycles:
  - exactly 3 requests are accepted and imem_req_valid then stays 0;
  - after release, 3 instructions drain in order and fetching resumes at address 3.
- With 2 fetches outstanding on a 3-cycle memory, pulse redirect with redirect_pc=16'h0040:
  - the 2 stale responses are dropped;
  - the first instruction delivered has out_pc_plus1=16'h0041.
- Assert redirect in the same cycle as a response and a pending request:
  - the response is dropped and no request is accepted that cycle;
  - the next request address is redirect_pc.
- Redirect to 16'hFFFE:
  - fetches are 16'hFFFE, 16'hFFFF, 16'h0000;
  - out_pc_plus1 values are 16'hFFFF, 16'h0000, 16'h0001.
- Assert reset while the queue is full and 0 fetches are outstanding:
  - the next cycle shows out_valid=0 and imem_req_valid=0;
  - the first post-reset request is at RESET_PC.
